sad_search_sequencer: RTL and testbench

SAD_SEARCH_SEQUENCER -- requirements
Module: sad_search_sequencer

---
 rtl/sad_ctrl_pkg.sv | 42 ++++
 rtl/sad_strobe_delay.sv | 31 +++
 rtl/sad_search_sequencer.sv | 156 +++++++++++++++
 tb/tb_sad_search_sequencer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sad_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sad_ctrl_pkg
// Description : Shared state, beat-kind and stride definitions for the SAD
//               search sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package sad_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    SCAN   = 3'd2,
    DRAIN  = 3'd3,
    RD_MIN = 3'd4,
    RD_TAG = 3'd5,
    DONE   = 3'd6
  } sad_state_t;

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    FSHIFT = 2'd1,
    WSHIFT = 2'd2
  } beat_kind_t;

  // One issued read as it travels down the delay line.
  typedef struct packed {
    logic        valid;
    beat_kind_t  kind;
    logic [31:0] addr;
  } beat_t;

  localparam logic [31:0] C_PAIR_STRIDE = 32'd4;

  function automatic beat_kind_t beat_kind(input logic first_row, input logic first_col);
    if (first_row && first_col) return SEED;
    else if (first_col)         return FSHIFT;
    else                        return WSHIFT;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sad_strobe_delay.sv
`default_nettype none
// ============================================================================
// Module      : sad_strobe_delay
// Description : Fixed-depth register delay line; flushed to zero on reset.
// Revision    : 1.0 - initial release
// ============================================================================
module sad_strobe_delay #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] r_pipe [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= din;
      for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign dout = r_pipe[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/sad_search_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sad_search_sequencer
// Description : Walks a ROWS x COLS candidate grid, steers the SAD unit and
//               reads back the minimum SAD and its tag.
// Revision    : 1.0 - initial release
// ============================================================================
module sad_search_sequencer
  import sad_ctrl_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int ROW_STRIDE = 64,
  parameter int PIPE_LAT   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [31:0] sad_value,
  output logic        busy,
  output logic        done,
  output logic        mem_rd,
  output logic [31:0] mem_addr,
  output logic [31:0] tag_addr,
  output logic        frame_shift,
  output logic        window_shift,
  output logic        min_in,
  output logic        load_min,
  output logic        clear_min,
  output logic [12:0] best_sad,
  output logic [31:0] best_tag
);

  localparam int c_beat_w = $bits(beat_t);

  sad_state_t  r_state, w_next;
  logic [15:0] r_row, r_col, r_drain;
  logic [31:0] r_row_addr, r_col_off;
  logic        w_last_beat, w_drain_end;
  beat_t       w_beat_in, w_beat_out;

  assign w_last_beat = (r_row == 16'(ROWS - 1)) && (r_col == 16'(COLS - 1));
  assign w_drain_end = (r_drain == 16'(PIPE_LAT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    busy      = 1'b0;
    done      = 1'b0;
    mem_rd    = 1'b0;
    mem_addr  = '0;
    clear_min = 1'b0;
    load_min  = 1'b0;
    case (r_state)
      IDLE:   if (start) w_next = CLEAR;
      CLEAR: begin
        busy      = 1'b1;
        clear_min = 1'b1;
        w_next    = SCAN;
      end
      SCAN: begin
        busy     = 1'b1;
        mem_rd   = 1'b1;
        mem_addr = r_row_addr + r_col_off;
        if (w_last_beat) w_next = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (w_drain_end) w_next = RD_MIN;
      end
      RD_MIN: begin
        busy     = 1'b1;
        load_min = 1'b1;
        w_next   = RD_TAG;
      end
      RD_TAG: begin
        busy   = 1'b1;
        w_next = DONE;
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Row base and column offset are kept separately so each beat is one add.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row      <= '0;
      r_col      <= '0;
      r_drain    <= '0;
      r_row_addr <= '0;
      r_col_off  <= '0;
      best_sad   <= '0;
      best_tag   <= '0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_row      <= '0;
          r_col      <= '0;
          r_drain    <= '0;
          r_row_addr <= base_addr;
          r_col_off  <= '0;
        end
        SCAN: begin
          if (r_col == 16'(COLS - 1)) begin
            r_col      <= '0;
            r_col_off  <= '0;
            r_row      <= r_row + 16'd1;
            r_row_addr <= r_row_addr + 32'(ROW_STRIDE);
          end else begin
            r_col     <= r_col + 16'd1;
            r_col_off <= r_col_off + C_PAIR_STRIDE;
          end
        end
        DRAIN:   r_drain  <= r_drain + 16'd1;
        RD_MIN:  best_sad <= sad_value[12:0];
        RD_TAG:  best_tag <= sad_value;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_beat_in       = '0;
    w_beat_in.valid = mem_rd;
    if (mem_rd) begin
      w_beat_in.kind = beat_kind(r_row == 16'd0, r_col == 16'd0);
      w_beat_in.addr = mem_addr;
    end
  end

  sad_strobe_delay #(
    .DEPTH (PIPE_LAT),
    .WIDTH (c_beat_w)
  ) u_strobe_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (w_beat_in),
    .dout  (w_beat_out)
  );

  assign min_in       = w_beat_out.valid;
  assign frame_shift  = w_beat_out.valid && (w_beat_out.kind == FSHIFT);
  assign window_shift = w_beat_out.valid && (w_beat_out.kind == WSHIFT);
  assign tag_addr     = w_beat_out.valid ? w_beat_out.addr : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_sad_search_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sad_search_sequencer
// Description : Scoreboard bench for the SAD search sequencer (2x2 grid).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sad_search_sequencer;

  localparam int ROWS       = 2;
  localparam int COLS       = 2;
  localparam int ROW_STRIDE = 64;
  localparam int PIPE_LAT   = 2;
  localparam int N_BEATS    = ROWS * COLS;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [31:0] sad_value;
  logic        busy, done, mem_rd, frame_shift, window_shift, min_in, load_min, clear_min;
  logic [31:0] mem_addr, tag_addr, best_tag;
  logic [12:0] best_sad;

  sad_search_sequencer #(
    .ROWS(ROWS), .COLS(COLS), .ROW_STRIDE(ROW_STRIDE), .PIPE_LAT(PIPE_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .sad_value(sad_value), .busy(busy), .done(done), .mem_rd(mem_rd),
    .mem_addr(mem_addr), .tag_addr(tag_addr), .frame_shift(frame_shift),
    .window_shift(window_shift), .min_in(min_in), .load_min(load_min),
    .clear_min(clear_min), .best_sad(best_sad), .best_tag(best_tag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  // SAD unit model: min register on load_min, tag register otherwise.
  logic [12:0] model_sad = '0;
  logic [31:0] model_tag = '0;
  always_comb sad_value = load_min ? {19'h7FFFF, model_sad} : model_tag;

  typedef struct {
    logic [31:0] addr;
    int          cyc;
    int          kind;   // 0 seed, 1 frame, 2 window
  } beat_exp_t;

  beat_exp_t rd_q[$];
  beat_exp_t tag_q[$];
  int        done_q[$];
  int        clr_q[$];
  int        ld_q[$];

  task automatic push_search(input logic [31:0] base, input int s);
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        beat_exp_t e;
        int i = r * COLS + c;
        e.addr = base + 32'(r * ROW_STRIDE) + 32'(c * 4);
        e.kind = (i == 0) ? 0 : (c == 0) ? 1 : 2;
        e.cyc  = s + 2 + i;
        rd_q.push_back(e);
        e.cyc  = s + 2 + i + PIPE_LAT;
        tag_q.push_back(e);
      end
    end
    clr_q.push_back(s + 1);
    ld_q.push_back(s + 2 + N_BEATS + PIPE_LAT);
    done_q.push_back(s + 1 + N_BEATS + PIPE_LAT + 2 + 1);
  endtask

  always @(negedge clk) begin
    beat_exp_t e;
    int        k;
    int        x;
    if (rst_n) begin
      if (mem_rd) begin
        checks++;
        if (rd_q.size() == 0) begin
          errors++;
          $display("FAIL rd_unexpected: addr=%h cyc=%0d", mem_addr, cyc);
        end else begin
          e = rd_q.pop_front();
          if (mem_addr !== e.addr || cyc !== e.cyc) begin
            errors++;
            $display("FAIL rd_beat: addr=%h cyc=%0d, want addr=%h cyc=%0d", mem_addr, cyc, e.addr, e.cyc);
          end
        end
      end
      k = (frame_shift && window_shift) ? 3 : window_shift ? 2 : frame_shift ? 1 : 0;
      checks++;
      if (min_in) begin
        if (tag_q.size() == 0) begin
          errors++;
          $display("FAIL tag_unexpected: tag=%h kind=%0d cyc=%0d", tag_addr, k, cyc);
        end else begin
          e = tag_q.pop_front();
          if (tag_addr !== e.addr || k !== e.kind || cyc !== e.cyc) begin
            errors++;
            $display("FAIL tag_beat: tag=%h kind=%0d cyc=%0d, want tag=%h kind=%0d cyc=%0d",
                     tag_addr, k, cyc, e.addr, e.kind, e.cyc);
          end
        end
      end else if (k != 0 || tag_addr !== 32'd0) begin
        errors++;
        $display("FAIL idle_strobes: kind=%0d tag=%h, want 0 and 0", k, tag_addr);
      end
      if (clear_min) begin
        checks++;
        x = (clr_q.size() != 0) ? clr_q.pop_front() : -1;
        if (cyc !== x) begin
          errors++;
          $display("FAIL clear_min_cycle: cyc=%0d, want %0d", cyc, x);
        end
      end
      if (load_min) begin
        checks++;
        x = (ld_q.size() != 0) ? ld_q.pop_front() : -1;
        if (cyc !== x) begin
          errors++;
          $display("FAIL load_min_cycle: cyc=%0d, want %0d", cyc, x);
        end
      end
      if (done) begin
        done_cnt++;
        checks++;
        x = (done_q.size() != 0) ? done_q.pop_front() : -1;
        if (cyc !== x || busy !== 1'b0) begin
          errors++;
          $display("FAIL done_pulse: cyc=%0d busy=%b, want cyc=%0d busy=0", cyc, busy, x);
        end
      end
    end
  end

  task automatic launch(input logic [31:0] base, input logic [12:0] sv, input logic [31:0] tv);
    @(posedge clk); #1;
    start     = 1'b1;
    base_addr = base;
    model_sad = sv;
    model_tag = tv;
    push_search(base, cyc);
    @(posedge clk); #1;
    start     = 1'b0;
    base_addr = 32'hDEADBEEF;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_start: busy=%b, want 1", busy);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && done_q.size() != 0; i++) @(posedge clk);
    #1;
    checks++;
    if (done_q.size() != 0 || rd_q.size() != 0 || tag_q.size() != 0 || ld_q.size() != 0 || clr_q.size() != 0) begin
      errors++;
      $display("FAIL search_timeout: pending done=%0d rd=%0d tag=%0d, want 0 0 0",
               done_q.size(), rd_q.size(), tag_q.size());
      done_q.delete(); rd_q.delete(); tag_q.delete(); ld_q.delete(); clr_q.delete();
    end
  endtask

  task automatic check_best(input string name, input logic [12:0] es, input logic [31:0] et);
    checks++;
    if (best_sad !== es || best_tag !== et) begin
      errors++;
      $display("FAIL %s: best_sad=%0d best_tag=%h, want %0d %h", name, best_sad, best_tag, es, et);
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({busy, done, mem_rd, frame_shift, window_shift, min_in, load_min, clear_min} !== 8'd0 ||
        mem_addr !== 32'd0 || tag_addr !== 32'd0 || best_sad !== 13'd0 || best_tag !== 32'd0) begin
      errors++;
      $display("FAIL %s: ctl=%b mem_addr=%h tag=%h best=%0d/%h, want all 0", name,
               {busy, done, mem_rd, frame_shift, window_shift, min_in, load_min, clear_min},
               mem_addr, tag_addr, best_sad, best_tag);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_outputs");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("idle_after_release");
  endtask

  task automatic test_basic();
    launch(32'h100, 13'd37, 32'h144);
    wait_idle();
    check_best("basic_best", 13'd37, 32'h144);
  endtask

  task automatic test_wrap();
    launch(32'hFFFFFFFC, 13'h1ABC, 32'hCAFE0040);
    wait_idle();
    check_best("wrap_best", 13'h1ABC, 32'hCAFE0040);
    model_sad = 13'd1;
    model_tag = 32'h1;
    repeat (5) @(posedge clk);
    #1;
    check_best("best_hold", 13'h1ABC, 32'hCAFE0040);
  endtask

  task automatic test_reset_mid();
    int d0;
    launch(32'h200, 13'd5, 32'h55);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("abort_outputs");
    rd_q.delete(); tag_q.delete(); done_q.delete(); ld_q.delete(); clr_q.delete();
    d0 = done_cnt;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    checks++;
    if (done_cnt !== d0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_done: dones=%0d busy=%b, want %0d 0", done_cnt - d0, busy, 0);
    end
    launch(32'h300, 13'd99, 32'h33C);
    wait_idle();
    check_best("after_abort_best", 13'd99, 32'h33C);
  endtask

  task automatic test_back_to_back();
    int s;
    @(posedge clk); #1;
    start     = 1'b1;
    base_addr = 32'h400;
    model_sad = 13'd7;
    model_tag = 32'h444;
    s = cyc;
    push_search(32'h400, s);
    push_search(32'h400, s + 1 + N_BEATS + PIPE_LAT + 2 + 1 + 1);
    repeat (1 + N_BEATS + PIPE_LAT + 2 + 1 + 1) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL held_start_idle: busy=%b, want 0", busy);
    end
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL held_start_restart: busy=%b, want 1", busy);
    end
    wait_idle();
    check_best("back_to_back_best", 13'd7, 32'h444);
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done_q.size() != 0) begin
      errors++;
      $display("FAIL no_queued_search: busy=%b, want 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
